// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alarm_pkg
// Brief    : Shared types, limits and the hh:mm validity check for the clock.
// Revision : 1.0 - initial release
// ============================================================================
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_t;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;
  localparam int SEC_MAX  = 59;

  typedef struct packed {
    logic [1:0] hour1;
    logic [3:0] hour0;
    logic [3:0] min1;
    logic [3:0] min0;
  } bcd_time_t;

  // Digits must be legal BCD and the resulting hh:mm must be a real time of day.
  function automatic logic time_valid(bcd_time_t t);
    int hours;
    int minutes;
    hours   = int'(t.hour1) * 10 + int'(t.hour0);
    minutes = int'(t.min1) * 10 + int'(t.min0);
    return (t.hour0 <= 4'd9) && (t.min0 <= 4'd9) && (t.min1 <= 4'd5) &&
           (hours <= HOUR_MAX) && (minutes <= MIN_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_alarm_clock_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_alarm_clock_if
// Brief    : Control/status bundle between the board logic and the alarm clock.
// Revision : 1.0 - initial release
// ============================================================================
interface multi_alarm_clock_if #(
  parameter int NUM_ALARMS = 4,
  parameter int MAX_SNOOZE = 3
);
  localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam int CNT_W = ($clog2(MAX_SNOOZE + 1) > 2) ? $clog2(MAX_SNOOZE + 1) : 2;

  logic [1:0]       hour_in1;
  logic [3:0]       hour_in0;
  logic [3:0]       minute_in1;
  logic [3:0]       minute_in0;
  logic             load_time;
  logic             load_alarm;
  logic [SEL_W-1:0] alarm_sel;
  logic             alarm_en_in;
  logic             snooze;
  logic             stop_alarm;
  logic             alarm;
  logic [SEL_W-1:0] ringing_slot;
  logic             snoozing;
  logic [CNT_W-1:0] snooze_count;
  logic [1:0]       hour_out1;
  logic [3:0]       hour_out0;
  logic [3:0]       minute_out1;
  logic [3:0]       minute_out0;
  logic [5:0]       seconds;

  modport master (
    output hour_in1, hour_in0, minute_in1, minute_in0, load_time, load_alarm,
           alarm_sel, alarm_en_in, snooze, stop_alarm,
    input  alarm, ringing_slot, snoozing, snooze_count,
           hour_out1, hour_out0, minute_out1, minute_out0, seconds
  );

  modport slave (
    input  hour_in1, hour_in0, minute_in1, minute_in0, load_time, load_alarm,
           alarm_sel, alarm_en_in, snooze, stop_alarm,
    output alarm, ringing_slot, snoozing, snooze_count,
           hour_out1, hour_out0, minute_out1, minute_out0, seconds
  );
endinterface
`default_nettype wire

// File: rtl/bcd_time_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_time_counter
// Brief    : BCD hh:mm plus binary seconds time-of-day counter with time load.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_time_counter
  import alarm_pkg::*;
(
  input  wire logic      clock_1s,
  input  wire logic      reset,
  input  wire logic      i_load,
  input  wire bcd_time_t i_time,
  output bcd_time_t      o_time,
  output logic [5:0]     o_seconds
);

  bcd_time_t  r_time;
  logic [5:0] r_sec;

  always_ff @(posedge clock_1s or posedge reset) begin
    if (reset) begin
      r_time <= '0;
      r_sec  <= '0;
    end else if (i_load && time_valid(i_time)) begin
      r_time <= i_time;
      r_sec  <= '0;
    end else if (r_sec == 6'(SEC_MAX)) begin
      r_sec <= '0;
      if (r_time.min0 == 4'd9) begin
        r_time.min0 <= 4'd0;
        if (r_time.min1 == 4'd5) begin
          r_time.min1 <= 4'd0;
          // 23 -> 00 rollover, otherwise ordinary BCD increment of the hour
          if (r_time.hour1 == 2'd2 && r_time.hour0 == 4'd3) begin
            r_time.hour1 <= 2'd0;
            r_time.hour0 <= 4'd0;
          end else if (r_time.hour0 == 4'd9) begin
            r_time.hour1 <= r_time.hour1 + 2'd1;
            r_time.hour0 <= 4'd0;
          end else begin
            r_time.hour0 <= r_time.hour0 + 4'd1;
          end
        end else begin
          r_time.min1 <= r_time.min1 + 4'd1;
        end
      end else begin
        r_time.min0 <= r_time.min0 + 4'd1;
      end
    end else begin
      r_sec <= r_sec + 6'd1;
    end
  end

  assign o_time    = r_time;
  assign o_seconds = r_sec;

endmodule
`default_nettype wire

// File: rtl/multi_alarm_clock.sv
`default_nettype none
// ============================================================================
// Module   : multi_alarm_clock
// Brief    : 24 h clock with NUM_ALARMS alarm slots and ring/snooze/stop control.
// Revision : 1.0 - initial release
// ============================================================================
module multi_alarm_clock
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3,
  parameter int RING_MAX_S = 60
) (
  input wire logic              clock_1s,
  input wire logic              reset,
  multi_alarm_clock_if.slave    bus
);

  localparam int SEL_W  = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam int CNT_W  = ($clog2(MAX_SNOOZE + 1) > 2) ? $clog2(MAX_SNOOZE + 1) : 2;
  localparam int SNZ_W  = $clog2(59 * 60 + 1);
  localparam int RING_W = $clog2(RING_MAX_S + 1);

  bcd_time_t       w_load;
  bcd_time_t       w_now;
  logic [5:0]      w_seconds;
  logic            w_sel_ok;
  logic            w_slot_wr;
  logic            w_cancel;
  logic            w_match;
  logic [SEL_W-1:0] w_match_idx;

  bcd_time_t       r_slot_time [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] r_slot_en;

  state_t          r_state;
  logic [SNZ_W-1:0]  r_snz_timer;
  logic [RING_W-1:0] r_ring_cnt;
  logic            r_alarm;
  logic            r_snoozing;
  logic [CNT_W-1:0] r_snooze_count;
  logic [SEL_W-1:0] r_ringing_slot;

  assign w_load = '{hour1: bus.hour_in1, hour0: bus.hour_in0,
                    min1:  bus.minute_in1, min0: bus.minute_in0};

  bcd_time_counter u_time (
    .clock_1s  (clock_1s),
    .reset     (reset),
    .i_load    (bus.load_time),
    .i_time    (w_load),
    .o_time    (w_now),
    .o_seconds (w_seconds)
  );

  assign w_sel_ok  = (int'(bus.alarm_sel) < NUM_ALARMS);
  assign w_slot_wr = bus.load_alarm && w_sel_ok && time_valid(w_load);
  // Rewriting the slot that owns the live event abandons that event.
  assign w_cancel  = w_slot_wr && (bus.alarm_sel == r_ringing_slot) && (r_state != IDLE);

  always_ff @(posedge clock_1s or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
        r_slot_time[k] <= '0;
      end
      r_slot_en <= '0;
    end else if (w_slot_wr) begin
      r_slot_time[bus.alarm_sel] <= w_load;
      r_slot_en[bus.alarm_sel]   <= bus.alarm_en_in;
    end
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
      if (r_slot_en[k] && (r_slot_time[k] == w_now) && (w_seconds == 6'd0) && !bus.load_time) begin
        w_match     = 1'b1;
        w_match_idx = SEL_W'(k);
      end
    end
  end

  always_ff @(posedge clock_1s or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_snz_timer    <= '0;
      r_ring_cnt     <= '0;
      r_alarm        <= 1'b0;
      r_snoozing     <= 1'b0;
      r_snooze_count <= '0;
      r_ringing_slot <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_match) begin
            r_state        <= RINGING;
            r_alarm        <= 1'b1;
            r_ringing_slot <= w_match_idx;
            r_ring_cnt     <= '0;
            r_snooze_count <= '0;
          end
        end
        RINGING: begin
          if (w_cancel || bus.stop_alarm) begin
            r_state <= IDLE;
            r_alarm <= 1'b0;
          end else if (bus.snooze) begin
            r_alarm <= 1'b0;
            if (r_snooze_count < CNT_W'(MAX_SNOOZE)) begin
              r_state        <= SNOOZED;
              r_snoozing     <= 1'b1;
              r_snz_timer    <= SNZ_W'(SNOOZE_MIN * 60 - 1);
              r_snooze_count <= r_snooze_count + 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else if (r_ring_cnt == RING_W'(RING_MAX_S - 1)) begin
            r_state <= IDLE;
            r_alarm <= 1'b0;
          end else begin
            r_ring_cnt <= r_ring_cnt + 1'b1;
          end
        end
        SNOOZED: begin
          if (w_cancel || bus.stop_alarm) begin
            r_state    <= IDLE;
            r_snoozing <= 1'b0;
          end else if (r_snz_timer == '0) begin
            r_state    <= RINGING;
            r_alarm    <= 1'b1;
            r_snoozing <= 1'b0;
            r_ring_cnt <= '0;
          end else begin
            r_snz_timer <= r_snz_timer - 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_alarm    <= 1'b0;
          r_snoozing <= 1'b0;
        end
      endcase
    end
  end

  assign bus.alarm        = r_alarm;
  assign bus.snoozing     = r_snoozing;
  assign bus.snooze_count = r_snooze_count;
  assign bus.ringing_slot = r_ringing_slot;
  assign bus.hour_out1    = w_now.hour1;
  assign bus.hour_out0    = w_now.hour0;
  assign bus.minute_out1  = w_now.min1;
  assign bus.minute_out0  = w_now.min0;
  assign bus.seconds      = w_seconds;

endmodule
`default_nettype wire

// File: tb/tb_multi_alarm_clock.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_alarm_clock
// Brief    : Directed plus randomized bench against a seconds-of-day event model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_alarm_clock;

  localparam int N          = 4;
  localparam int SNOOZE_MIN = 5;
  localparam int MAX_SNOOZE = 3;
  localparam int RING_MAX_S = 60;

  logic clock_1s = 1'b0;
  logic reset    = 1'b0;

  multi_alarm_clock_if #(.NUM_ALARMS(N), .MAX_SNOOZE(MAX_SNOOZE)) bus ();

  multi_alarm_clock #(
    .NUM_ALARMS (N),
    .SNOOZE_MIN (SNOOZE_MIN),
    .MAX_SNOOZE (MAX_SNOOZE),
    .RING_MAX_S (RING_MAX_S)
  ) dut (
    .clock_1s (clock_1s),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clock_1s = ~clock_1s;

  int errors = 0;
  int checks = 0;

  // Reference: time as seconds of day, slots as minute of day, event as flags/counters.
  int m_tod;
  int m_slot_min [N];
  bit m_slot_en  [N];
  bit m_ring;
  bit m_snz;
  int m_age;
  int m_left;
  int m_used;
  int m_owner;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_time(int h, int m, int s);
    return 32'(((h / 10) << 18) | ((h % 10) << 14) | ((m / 10) << 10) | ((m % 10) << 6) | s);
  endfunction

  function automatic logic [31:0] obs_time();
    return 32'({bus.hour_out1, bus.hour_out0, bus.minute_out1, bus.minute_out0, bus.seconds});
  endfunction

  function automatic bit ok_time(int h1, int h0, int m1, int m0);
    return (h0 < 10) && (m0 < 10) && (m1 < 6) && ((h1 * 10 + h0) < 24);
  endfunction

  task automatic model_reset();
    m_tod = 0;
    for (int k = 0; k < N; k++) begin
      m_slot_min[k] = 0;
      m_slot_en[k]  = 0;
    end
    m_ring = 0; m_snz = 0; m_age = 0; m_left = 0; m_used = 0; m_owner = 0;
  endtask

  task automatic model_update();
    int h1, h0, mt, mu, minute_of_day, hit, sel;
    bit v, wr, cancel;
    h1 = int'(bus.hour_in1); h0 = int'(bus.hour_in0);
    mt = int'(bus.minute_in1); mu = int'(bus.minute_in0);
    sel = int'(bus.alarm_sel);
    v = ok_time(h1, h0, mt, mu);
    minute_of_day = (h1 * 10 + h0) * 60 + mt * 10 + mu;
    hit = -1;
    if ((m_tod % 60) == 0 && !bus.load_time) begin
      for (int k = 0; k < N; k++) begin
        if (hit < 0 && m_slot_en[k] && m_slot_min[k] == m_tod / 60) hit = k;
      end
    end
    wr = bus.load_alarm && (sel < N) && v;
    cancel = wr && (sel == m_owner) && (m_ring || m_snz);
    if (m_ring) begin
      if (cancel || bus.stop_alarm) m_ring = 0;
      else if (bus.snooze) begin
        m_ring = 0;
        if (m_used < MAX_SNOOZE) begin
          m_snz = 1; m_left = SNOOZE_MIN * 60; m_used++;
        end
      end else begin
        m_age++;
        if (m_age >= RING_MAX_S) m_ring = 0;
      end
    end else if (m_snz) begin
      if (cancel || bus.stop_alarm) m_snz = 0;
      else begin
        m_left--;
        if (m_left == 0) begin m_snz = 0; m_ring = 1; m_age = 0; end
      end
    end else if (hit >= 0) begin
      m_ring = 1; m_owner = hit; m_age = 0; m_used = 0;
    end
    if (bus.load_time && v) m_tod = minute_of_day * 60;
    else m_tod = (m_tod + 1) % 86400;
    if (wr) begin
      m_slot_min[sel] = minute_of_day;
      m_slot_en[sel]  = bus.alarm_en_in;
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clock_1s);
    #1;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic check_all(string tag);
    int hh, mm;
    hh = m_tod / 3600;
    mm = (m_tod / 60) % 60;
    check({tag, ".time"}, obs_time(), pack_time(hh, mm, m_tod % 60));
    check({tag, ".alarm"}, 32'(bus.alarm), 32'(m_ring));
    check({tag, ".snoozing"}, 32'(bus.snoozing), 32'(m_snz));
    check({tag, ".snooze_count"}, 32'(bus.snooze_count), 32'(m_used));
    if (m_ring || m_snz) check({tag, ".slot"}, 32'(bus.ringing_slot), 32'(m_owner));
  endtask

  task automatic drive_idle();
    bus.hour_in1 = '0; bus.hour_in0 = '0; bus.minute_in1 = '0; bus.minute_in0 = '0;
    bus.load_time = 0; bus.load_alarm = 0; bus.alarm_sel = '0; bus.alarm_en_in = 0;
    bus.snooze = 0; bus.stop_alarm = 0;
  endtask

  task automatic set_digits(int h, int m);
    bus.hour_in1   = 2'(h / 10);
    bus.hour_in0   = 4'(h % 10);
    bus.minute_in1 = 4'(m / 10);
    bus.minute_in0 = 4'(m % 10);
  endtask

  task automatic do_load_time(int h, int m);
    set_digits(h, m);
    bus.load_time = 1;
    step();
    bus.load_time = 0;
  endtask

  task automatic do_load_alarm(int sel, int h, int m, bit en);
    set_digits(h, m);
    bus.alarm_sel   = 2'(sel);
    bus.alarm_en_in = en;
    bus.load_alarm  = 1;
    step();
    bus.load_alarm = 0;
  endtask

  task automatic pulse_snooze();
    bus.snooze = 1;
    step();
    bus.snooze = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tgt;
    drive_idle();
    model_reset();
    #1 reset = 1;
    #1;
    check_all("reset");
    check("reset.slot", 32'(bus.ringing_slot), 32'd0);
    check("reset.time0", obs_time(), pack_time(0, 0, 0));
    #1 reset = 0;

    run(3661);
    check("count3661", obs_time(), pack_time(1, 1, 1));
    do_load_time(23, 59);
    check("load2359", obs_time(), pack_time(23, 59, 0));
    run(60);
    check("midnight", obs_time(), pack_time(0, 0, 0));
    check_all("midnight");

    // Slot 2 fires one edge after the display reaches 07:30:00.
    do_load_alarm(2, 7, 30, 1);
    do_load_time(7, 29);
    run(60);
    check("pre_match.time", obs_time(), pack_time(7, 30, 0));
    check("pre_match.alarm", 32'(bus.alarm), 32'd0);
    step();
    check("match.alarm", 32'(bus.alarm), 32'd1);
    check("match.slot", 32'(bus.ringing_slot), 32'd2);
    check("match.time", obs_time(), pack_time(7, 30, 1));

    run(4);
    pulse_snooze();
    check("snz1.snoozing", 32'(bus.snoozing), 32'd1);
    check("snz1.alarm", 32'(bus.alarm), 32'd0);
    check("snz1.count", 32'(bus.snooze_count), 32'd1);
    run(299);
    check("snz1.wait299", 32'(bus.alarm), 32'd0);
    step();
    check("snz1.resume", 32'(bus.alarm), 32'd1);
    check("snz1.resume_snz", 32'(bus.snoozing), 32'd0);
    repeat (2) begin
      pulse_snooze();
      run(300);
      check_all("snz_cycle");
    end
    check("snz3.count", 32'(bus.snooze_count), 32'd3);
    pulse_snooze();
    check("snz4.alarm", 32'(bus.alarm), 32'd0);
    check("snz4.snoozing", 32'(bus.snoozing), 32'd0);
    check("snz4.count", 32'(bus.snooze_count), 32'd3);

    // Unattended ringing times out after RING_MAX_S edges.
    do_load_alarm(1, 8, 0, 1);
    do_load_time(7, 59);
    run(61);
    check("tmo.start", 32'(bus.alarm), 32'd1);
    run(59);
    check("tmo.still", 32'(bus.alarm), 32'd1);
    step();
    check("tmo.drop", 32'(bus.alarm), 32'd0);
    check_all("tmo");

    // Stop and snooze together: stop wins and the count is left alone.
    do_load_alarm(1, 8, 10, 1);
    do_load_time(8, 9);
    run(61);
    pulse_snooze();
    run(300);
    check("both.ring", 32'(bus.alarm), 32'd1);
    bus.stop_alarm = 1; bus.snooze = 1;
    step();
    bus.stop_alarm = 0; bus.snooze = 0;
    check("both.alarm", 32'(bus.alarm), 32'd0);
    check("both.snoozing", 32'(bus.snoozing), 32'd0);
    check("both.count", 32'(bus.snooze_count), 32'd1);

    do_load_alarm(0, 6, 0, 0);
    do_load_alarm(1, 6, 0, 1);
    do_load_alarm(3, 6, 0, 1);
    do_load_time(5, 59);
    run(61);
    check("prio.alarm", 32'(bus.alarm), 32'd1);
    check("prio.slot", 32'(bus.ringing_slot), 32'd1);
    bus.stop_alarm = 1;
    step();
    bus.stop_alarm = 0;
    check("stop.alarm", 32'(bus.alarm), 32'd0);

    do_load_alarm(1, 6, 0, 0);
    do_load_alarm(3, 6, 0, 0);
    do_load_time(5, 59);
    run(61);
    check("disabled.alarm", 32'(bus.alarm), 32'd0);
    check_all("disabled");

    do_load_time(25, 0);
    check("bad_hour", obs_time(), pack_time(6, 0, 2));
    do_load_time(6, 61);
    check("bad_min", obs_time(), pack_time(6, 0, 3));

    do_load_alarm(3, 6, 5, 1);
    do_load_time(6, 4);
    run(61);
    check("reload.ring", 32'(bus.alarm), 32'd1);
    check("reload.slot", 32'(bus.ringing_slot), 32'd3);
    do_load_alarm(3, 6, 5, 1);
    check("reload.cancel", 32'(bus.alarm), 32'd0);
    check_all("reload");

    do_load_time(6, 4);
    run(63);
    check("arst.ring", 32'(bus.alarm), 32'd1);
    #2 reset = 1;
    #1;
    check("arst.alarm", 32'(bus.alarm), 32'd0);
    check("arst.time", obs_time(), pack_time(0, 0, 0));
    model_reset();
    #1 reset = 0;
    do_load_time(6, 4);
    run(61);
    check("arst.slots_cleared", 32'(bus.alarm), 32'd0);

    for (int i = 0; i < 800; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      bus.snooze      = (r < 6);
      bus.stop_alarm  = (r >= 6 && r < 8);
      bus.load_time   = ($urandom_range(0, 199) == 0);
      bus.load_alarm  = ($urandom_range(0, 19) == 0);
      bus.alarm_sel   = 2'($urandom);
      bus.alarm_en_in = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.hour_in1   = 2'($urandom);
        bus.hour_in0   = 4'($urandom);
        bus.minute_in1 = 4'($urandom);
        bus.minute_in0 = 4'($urandom);
      end else begin
        tgt = (m_tod / 60 + int'($urandom_range(0, 2))) % 1440;
        set_digits(tgt / 60, tgt % 60);
      end
      step();
      check_all("rand");
    end
    drive_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
